ppu_vram_arbiter: RTL and testbench

Shares the PPU's single VRAM/CHR memory port among three requesters: the background/sprite render fetcher, the CPU PPUDATA ($2007) path and a debug/DMA port. Each access takes two clocks, matching the NES PPU's two-cycle memory access. The block uses a two-state sequencer with fixed priority plus a CPU starvation guard. It sits between the PPU fetch logic and the VRAM/pattern-ROM interface, and is paced by a clock-enable from the existing clock divider.

---
 rtl/ppu_vram_arbiter.sv | 140 ++++++++++++++
 tb/tb_ppu_vram_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_arbiter.sv
// Two-clock VRAM/CHR port sequencer shared by the render fetcher, CPU PPUDATA and debug/DMA.
// Fixed priority render > cpu > dbg, with a CPU starvation guard that pre-empts render.
module ppu_vram_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_en,
    input  logic              render_req,
    input  logic [ADDR_W-1:0] render_addr,
    output logic              render_gnt,
    output logic              render_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic {ARB, BUSY} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_RENDER, SRC_CPU, SRC_DBG} src_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t     state;
    src_t       winner;
    src_t       owner;
    logic [3:0] cpu_wait;
    logic       take;

    always_comb begin
        winner = SRC_NONE;
        if (cpu_req && cpu_wait == WAIT_LIMIT) winner = SRC_CPU;
        else if (render_req)                   winner = SRC_RENDER;
        else if (cpu_req)                      winner = SRC_CPU;
        else if (dbg_req)                      winner = SRC_DBG;
    end

    assign take = (state == ARB) && mem_en && (winner != SRC_NONE);
    assign busy = (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARB;
            owner         <= SRC_NONE;
            render_gnt    <= 1'b0;
            cpu_gnt       <= 1'b0;
            dbg_gnt       <= 1'b0;
            render_rvalid <= 1'b0;
            cpu_rvalid    <= 1'b0;
            dbg_rvalid    <= 1'b0;
            mem_cs        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            rdata         <= '0;
        end else begin
            render_gnt    <= 1'b0;
            cpu_gnt       <= 1'b0;
            dbg_gnt       <= 1'b0;
            render_rvalid <= 1'b0;
            cpu_rvalid    <= 1'b0;
            dbg_rvalid    <= 1'b0;
            mem_cs        <= 1'b0;
            mem_we        <= 1'b0;
            case (state)
                ARB: begin
                    if (take) begin
                        state  <= BUSY;
                        owner  <= winner;
                        mem_cs <= 1'b1;
                        case (winner)
                            SRC_RENDER: begin
                                render_gnt <= 1'b1;
                                mem_addr   <= render_addr;
                                mem_we     <= 1'b0;
                                mem_wdata  <= '0;
                            end
                            SRC_CPU: begin
                                cpu_gnt   <= 1'b1;
                                mem_addr  <= cpu_addr;
                                mem_we    <= cpu_we;
                                mem_wdata <= cpu_wdata;
                            end
                            SRC_DBG: begin
                                dbg_gnt   <= 1'b1;
                                mem_addr  <= dbg_addr;
                                mem_we    <= dbg_we;
                                mem_wdata <= dbg_wdata;
                            end
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    state <= ARB;
                    // Read data is captured on the edge closing BUSY so it is valid in the return clock.
                    if (!mem_we) begin
                        rdata <= mem_rdata;
                        case (owner)
                            SRC_RENDER: render_rvalid <= 1'b1;
                            SRC_CPU:    cpu_rvalid    <= 1'b1;
                            SRC_DBG:    dbg_rvalid    <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_wait <= '0;
        end else if (!cpu_req) begin
            cpu_wait <= '0;
        end else if (take) begin
            if (winner == SRC_CPU)          cpu_wait <= '0;
            else if (cpu_wait < WAIT_LIMIT) cpu_wait <= cpu_wait + 4'd1;
        end
    end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Scoreboarded bench for ppu_vram_arbiter: expected read returns are queued when requests are
// driven and popped by a monitor on every rvalid; grant timing is checked inline.
module tb_ppu_vram_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam logic [2:0] W_R = 3'b100;
    localparam logic [2:0] W_C = 3'b010;
    localparam logic [2:0] W_D = 3'b001;
    localparam logic [2:0] PRI_SEQ [6] = '{W_R, W_R, W_R, W_R, W_C, W_R};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_en = 1'b0;
    logic              render_req = 1'b0;
    logic [ADDR_W-1:0] render_addr = '0;
    logic              render_gnt, render_rvalid;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_gnt, cpu_rvalid;
    logic              dbg_req = 1'b0, dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic              dbg_gnt, dbg_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              mem_cs, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] who;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    ppu_vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_en(mem_en),
        .render_req(render_req), .render_addr(render_addr),
        .render_gnt(render_gnt), .render_rvalid(render_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .rdata(rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pattern(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Synchronous RAM whose address register is the arbiter's mem_addr.
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = pattern(ADDR_W'(i));
        mem[14'h1234] = 8'hA5;
    end
    always @(posedge clk) if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    logic [38:0] all_outs;
    assign all_outs = {render_gnt, render_rvalid, cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid,
                       rdata, mem_cs, mem_we, mem_addr, mem_wdata, busy};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_read(input logic [2:0] who, input logic [7:0] data);
        exp_t e;
        e.who  = who;
        e.data = data;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (render_rvalid || cpu_rvalid || dbg_rvalid)) begin
            if (sb.size() == 0) begin
                check("rv_unexpected", {render_rvalid, cpu_rvalid, dbg_rvalid}, 3'b000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rv_who", {render_rvalid, cpu_rvalid, dbg_rvalid}, e.who);
                check("rv_data", rdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check("reset_outs", all_outs, 39'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single render read
        mem_en = 1'b1;
        render_req = 1'b1; render_addr = 14'h1234;
        expect_read(W_R, 8'hA5);
        @(negedge clk);
        check("rd_gnt", {render_gnt, mem_cs, mem_we, busy}, 4'b1101);
        check("rd_addr", mem_addr, 14'h1234);
        render_req = 1'b0;
        @(negedge clk);
        check("rd_rvalid", render_rvalid, 1'b1);
        check("rd_data", rdata, 8'hA5);
        check("rd_idle_cs", {mem_cs, busy}, 2'b00);

        // CPU write: no rvalid ever
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2005; cpu_wdata = 8'h3C;
        @(negedge clk);
        check("wr_gnt", {cpu_gnt, mem_cs, mem_we}, 3'b111);
        check("wr_addr", mem_addr, 14'h2005);
        check("wr_data", mem_wdata, 8'h3C);
        cpu_req = 1'b0; cpu_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wr_no_rvalid", cpu_rvalid, 1'b0);
        end

        // Priority with starvation guard
        render_addr = 14'h0100; cpu_addr = 14'h0200; dbg_addr = 14'h0300;
        render_req = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            expect_read(PRI_SEQ[k], (PRI_SEQ[k] == W_C) ? pattern(14'h0200) : pattern(14'h0100));
            @(negedge clk);
            check("pri_gnt", {render_gnt, cpu_gnt, dbg_gnt}, PRI_SEQ[k]);
            if (PRI_SEQ[k] == W_C) cpu_req = 1'b0;
            @(negedge clk);
        end
        render_req = 1'b0;
        expect_read(W_D, pattern(14'h0300));
        @(negedge clk);
        check("pri_dbg_gnt", {render_gnt, cpu_gnt, dbg_gnt}, W_D);
        dbg_req = 1'b0;
        @(negedge clk);

        // mem_en paced once every 4 clocks
        render_req = 1'b1; render_addr = 14'h0400;
        for (int c = 0; c < 11; c++) begin
            mem_en = (c % 4 == 3);
            if (c % 4 == 3) expect_read(W_R, pattern(14'h0400));
            check("pace_gnt", render_gnt, (c >= 4 && c % 4 == 0));
            check("pace_rvalid", render_rvalid, (c >= 5 && c % 4 == 1));
            @(negedge clk);
        end
        render_req = 1'b0;
        mem_en = 1'b1;

        // Back-to-back render then CPU read
        render_req = 1'b1; render_addr = 14'h0500;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0600;
        expect_read(W_R, pattern(14'h0500));
        expect_read(W_C, pattern(14'h0600));
        @(negedge clk);
        check("b2b_rgnt", {render_gnt, cpu_gnt}, 2'b10);
        render_req = 1'b0;
        @(negedge clk);
        check("b2b_rrv", {render_rvalid, busy}, 2'b10);
        @(negedge clk);
        check("b2b_cgnt", {cpu_gnt, mem_addr}, {1'b1, 14'h0600});
        cpu_req = 1'b0;
        @(negedge clk);
        check("b2b_crv", cpu_rvalid, 1'b1);

        // Reset during BUSY of a CPU read aborts it
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0700;
        @(negedge clk);
        check("rst_cgnt", cpu_gnt, 1'b1);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("rst_outs_async", all_outs, 39'd0);
        @(negedge clk);
        check("rst_outs_held", all_outs, 39'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_rvalid", cpu_rvalid, 1'b0);
        end
        render_req = 1'b1; render_addr = 14'h1234;
        expect_read(W_R, 8'hA5);
        @(negedge clk);
        check("post_rst_gnt", {render_gnt, mem_cs}, 2'b11);
        render_req = 1'b0;
        @(negedge clk);
        check("post_rst_rv", {render_rvalid, rdata}, {1'b1, 8'hA5});
        @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
